// File: rtl/display_pkg.sv
// Shared display constants and arbiter state encoding.
package display_pkg;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned NUMBER_W = 4 * DIGITS;

  typedef logic state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t SHOW = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or above the pointer, wrapping to 0.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] pointer,
  output logic [PTR_W-1:0] winner,
  output logic             any
);

  logic [PTR_W-1:0] idx;

  // Scan from the farthest candidate down so the nearest set request wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = PTR_W'((32'(pointer) + 32'(k)) % N);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_share_arbiter.sv
// Round-robin owner of the shared hex display with a fixed non-preemptible show time.
module display_share_arbiter
  import display_pkg::*;
#(
  parameter int unsigned          N_REQ       = 4,
  parameter int unsigned          HOLD_CYCLES = 50000000,
  parameter int unsigned          HOLD_W      = 26,
  parameter logic [NUMBER_W-1:0]  RESET_VALUE = 16'h0000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [NUMBER_W*N_REQ-1:0] value,
  output logic [NUMBER_W-1:0]       number,
  output logic [N_REQ-1:0]          grant,
  output logic                      done,
  output logic                      busy
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  state_t             state;
  logic [HOLD_W-1:0]  counter;
  logic [PTR_W-1:0]   pointer;
  logic [PTR_W-1:0]   pointer_next;
  logic [PTR_W-1:0]   winner;
  logic               any;
  logic [NUMBER_W-1:0] slices [N_REQ];

  rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req     (req),
    .pointer (pointer),
    .winner  (winner),
    .any     (any)
  );

  // Unpack the flat value bus into per-requester slices.
  for (genvar i = 0; i < int'(N_REQ); i++) begin : g_slice
    assign slices[i] = value[NUMBER_W*i +: NUMBER_W];
  end

  // The winner drops to lowest priority on the next arbitration.
  assign pointer_next = (32'(winner) == N_REQ - 1) ? '0 : PTR_W'(winner + 1'b1);

  // Arbitration FSM: grant on request, hold for HOLD_CYCLES, re-arbitrate at expiry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      pointer <= '0;
      number  <= RESET_VALUE;
      grant   <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else if (state == IDLE || counter == '0) begin
      if (any) begin
        state   <= SHOW;
        counter <= HOLD_W'(HOLD_CYCLES - 1);
        pointer <= pointer_next;
        number  <= slices[winner];
        grant   <= N_REQ'(1) << winner;
        done    <= (HOLD_CYCLES == 1);
        busy    <= 1'b1;
      end else begin
        state   <= IDLE;
        grant   <= '0;
        done    <= 1'b0;
        busy    <= 1'b0;
      end
    end else begin
      counter <= counter - 1'b1;
      done    <= (counter == HOLD_W'(1));
    end
  end

endmodule

// File: tb/tb_display_share_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle model.
module tb_display_share_arbiter;

  localparam int unsigned HOLD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] vals [4];
  logic [63:0] value;
  logic [15:0] number;
  logic [3:0]  grant;
  logic        done;
  logic        busy;

  logic [3:0]  req1;
  logic [63:0] value1;
  logic [15:0] number1;
  logic [3:0]  grant1;
  logic        done1;
  logic        busy1;

  int n_checks = 0;
  int n_errors = 0;

  assign value  = {vals[3], vals[2], vals[1], vals[0]};
  assign value1 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

  always #5 clk = ~clk;

  display_share_arbiter #(.N_REQ(4), .HOLD_CYCLES(HOLD), .HOLD_W(3), .RESET_VALUE(16'h0000)) dut (
    .clock(clk), .reset(rst), .req(req), .value(value),
    .number(number), .grant(grant), .done(done), .busy(busy)
  );

  display_share_arbiter #(.N_REQ(4), .HOLD_CYCLES(1), .HOLD_W(2), .RESET_VALUE(16'h0000)) dut1 (
    .clock(clk), .reset(rst), .req(req1), .value(value1),
    .number(number1), .grant(grant1), .done(done1), .busy(busy1)
  );

  // Reference model: current owner, cycles left in its grant (including this one), pointer.
  logic        m_busy;
  logic [1:0]  m_owner;
  int          m_rem;
  logic [1:0]  m_ptr;
  logic [15:0] m_num;

  function automatic logic [1:0] rr_first(input logic [3:0] r, input logic [1:0] p);
    for (int k = 0; k < 4; k++)
      if (r[p + 2'(k)]) return p + 2'(k);
    return p;
  endfunction

  // Model advances once per clock using the inputs presented before the edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_owner <= 2'd0;
      m_rem   <= 0;
      m_ptr   <= 2'd0;
      m_num   <= 16'h0000;
    end else if (!m_busy || m_rem == 1) begin
      if (req != 4'b0) begin
        m_busy  <= 1'b1;
        m_owner <= rr_first(req, m_ptr);
        m_rem   <= HOLD;
        m_num   <= vals[rr_first(req, m_ptr)];
        m_ptr   <= rr_first(req, m_ptr) + 2'd1;
      end else begin
        m_busy  <= 1'b0;
      end
    end else begin
      m_rem <= m_rem - 1;
    end
  end

  logic [3:0] e_grant;
  logic       e_done;
  assign e_grant = m_busy ? (4'b0001 << m_owner) : 4'b0000;
  assign e_done  = m_busy && (m_rem == 1);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare the main DUT against the model.
  task automatic step();
    @(negedge clk);
    check("grant",  32'(grant),  32'(e_grant));
    check("number", 32'(number), 32'(m_num));
    check("busy",   32'(busy),   32'(m_busy));
    check("done",   32'(done),   32'(e_done));
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_grant",  32'(grant),  32'h0);
    check("rst_number", 32'(number), 32'h0);
    check("rst_busy",   32'(busy),   32'h0);
    check("rst_done",   32'(done),   32'h0);
    check("rst_grant1", 32'(grant1), 32'h0);
    rst = 1'b0;
  endtask

  int dones;

  initial begin
    rst  = 1'b1;
    req  = 4'b0;
    req1 = 4'b0;
    for (int i = 0; i < 4; i++) vals[i] = 16'(i * 16'h1111);
    @(negedge clk);
    @(negedge clk);
    check("reset_grant",  32'(grant),  32'h0);
    check("reset_number", 32'(number), 32'h0);
    check("reset_busy",   32'(busy),   32'h0);
    rst = 1'b0;

    // Single one-cycle request from requester 2.
    req = 4'b0100; vals[2] = 16'hBEEF;
    step();
    check("p1_grant", 32'(grant), 32'h4);
    check("p1_num", 32'(number), 32'hBEEF);
    req = 4'b0000;
    step(); step(); step();
    check("p1_done", 32'(done), 32'h1);
    step();
    check("p1_idle_grant", 32'(grant), 32'h0);
    check("p1_keep_num", 32'(number), 32'hBEEF);

    // All requesting: fixed rotation from pointer 0, no gaps.
    pulse_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) vals[i] = 16'hA000 + 16'(i);
    dones = 0;
    for (int s = 0; s < 20; s++) begin
      step();
      check("p2_order", 32'(grant), 32'(4'b0001 << ((s / 4) % 4)));
      if (done) dones++;
    end
    check("p2_dones", 32'(dones), 32'd5);

    // Snapshot holds while value changes and req drops.
    pulse_reset();
    req = 4'b0010; vals[1] = 16'hAAAA;
    step();
    vals[1] = 16'h1234; req = 4'b0000;
    check("p3_num0", 32'(number), 32'hAAAA);
    for (int s = 0; s < 3; s++) begin
      step();
      check("p3_num", 32'(number), 32'hAAAA);
      check("p3_grant", 32'(grant), 32'h2);
    end

    // Lone continuous requester: back-to-back grants, never idle.
    req = 4'b0100;
    dones = 0;
    for (int s = 0; s < 12; s++) begin
      step();
      check("p4_grant", 32'(grant), 32'h4);
      check("p4_busy", 32'(busy), 32'h1);
      if (done) dones++;
    end
    check("p4_dones", 32'(dones), 32'd3);

    // Reset in the second cycle of a grant restores the pointer.
    req = 4'b0000;
    step(); step(); step(); step(); step();
    req = 4'b0100;
    step(); step();
    pulse_reset();
    req = 4'b1010;
    step();
    check("p5_grant", 32'(grant), 32'h2);

    // One-cycle grants alternate every cycle.
    req = 4'b0000;
    pulse_reset();
    req1 = 4'b0011;
    for (int s = 0; s < 8; s++) begin
      step();
      check("p6_grant", 32'(grant1), (s % 2 == 0) ? 32'h1 : 32'h2);
      check("p6_num", 32'(number1), (s % 2 == 0) ? 32'h1111 : 32'h2222);
      check("p6_done", 32'(done1), 32'h1);
    end
    req1 = 4'b0000;

    // Random traffic against the model.
    for (int s = 0; s < 800; s++) begin
      step();
      if ($urandom_range(0, 79) == 0) pulse_reset();
      if ($urandom_range(0, 2) == 0) req = 4'($urandom);
      for (int i = 0; i < 4; i++) vals[i] = 16'($urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
